// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule blocks: round count, Rcon constants,
// state encoding and the reverse Rcon step.
package aes_pkg;

  localparam int         AES_NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_LAST      = 8'h36;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} iks_state_t;

  typedef logic [127:0] aes_key_t;

  // Division by x in GF(2^8): undoes the forward xtime so Rcon can walk 36 -> 01.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    if (r[0]) begin
      return ((r ^ 8'h1b) >> 1) | 8'h80;
    end
    return r >> 1;
  endfunction

endpackage

// File: rtl/g_function.sv
// AES key-expansion g transform: RotWord, SubWord, then Rcon into the most significant byte.
module g_function (
  input  logic [31:0] w,
  input  logic [7:0]  rcon,
  output logic [31:0] g
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [31:0] rot;

  assign rot = {w[23:0], w[31:24]};
  assign g   = {SBOX[rot[31:24]] ^ rcon, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};

endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key expansion: loads the round-10 key and walks back to the cipher key,
// presenting one round key per accepted handshake.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] final_key,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         busy,
  output logic         done
);

  // Handshake: a key transfers on a cycle with key_valid & key_ready; while key_valid is
  // high and key_ready low, round_key/round_num stay frozen until the transfer happens.

  iks_state_t state, state_next;
  aes_key_t   key_reg;
  logic [7:0] rcon_reg;
  logic [3:0] round_reg;
  logic       done_reg;

  logic       load, step, finish;
  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, g_out;
  aes_key_t   prev_key;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (round_reg == 4'd0) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Undo one forward step: later words are recovered by XOR, the first needs g() of w3.
  assign {w4, w5, w6, w7} = key_reg;
  assign w3 = w7 ^ w6;
  assign w2 = w6 ^ w5;
  assign w1 = w5 ^ w4;
  assign w0 = w4 ^ g_out;
  assign prev_key = {w0, w1, w2, w3};

  g_function u_g_function (
    .w    (w3),
    .rcon (rcon_reg),
    .g    (g_out)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      key_reg   <= '0;
      rcon_reg  <= '0;
      round_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= finish;
      if (load) begin
        key_reg   <= final_key;
        rcon_reg  <= RCON_LAST;
        round_reg <= 4'(NUM_ROUNDS);
      end else if (step) begin
        key_reg   <= prev_key;
        rcon_reg  <= inv_xtime(rcon_reg);
        round_reg <= round_reg - 4'd1;
      end
    end
  end

  assign key_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign round_key = key_reg;
  assign round_num = round_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: FIPS-197 vectors, back-pressure, reset and start corner cases,
// and random keys scored against an independent forward key-expansion model.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [127:0] final_key;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [131:0] exp_q[$];
  logic [7:0]   sbox_tb[256];
  logic [127:0] rk[11];
  logic [127:0] got_key[11];

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } vec_t;
  vec_t fips_tbl[4];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  inv_key_schedule dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .final_key (final_key),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .round_key (round_key),
    .round_num (round_num),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: S-box derived from GF(2^8) inverse + affine map, forward expansion
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // driver: mode 0 = ready always high, 1 = 1,0,0,1 then random, 2 = random.
  // poke_round >= 0 raises start while that round is presented.
  task automatic run_seq(input logic [127:0] ck, input int mode, input int poke_round);
    int          cycles;
    bit          rdy;
    bit          pat[4];
    logic [131:0] e;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    expand(ck);
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk[r]});
    for (int r = 0; r < 11; r++) got_key[r] = '0;
    check("idle_before_start", busy, 1'b0);
    start     = 1'b1;
    final_key = rk[10];
    key_ready = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    final_key = '0;
    check("start_latency_valid", key_valid, 1'b1);
    check("done_low_after_start", done, 1'b0);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 300) begin
      e = exp_q[0];
      check("round_num", round_num, e[131:128]);
      check("round_key", round_key, e[127:0]);
      check("key_valid_emit", key_valid, 1'b1);
      check("busy_emit", busy, 1'b1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles < 4) ? pat[cycles] : 1'($urandom_range(0, 1));
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      start     = (poke_round >= 0) && (e[131:128] == 4'(poke_round));
      final_key = ~rk[10];
      key_ready = rdy;
      if (rdy) begin
        got_key[e[131:128]] = round_key;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cycles++;
    end
    key_ready = 1'b0;
    start     = 1'b0;
    if (exp_q.size() != 0) begin
      check("sequence_timeout_remaining", 128'(exp_q.size()), 128'd0);
    end else begin
      check("done_pulse", done, 1'b1);
      check("valid_after_last", key_valid, 1'b0);
      check("busy_after_last", busy, 1'b0);
      check("round0_is_cipher_key", got_key[0], ck);
      if (mode == 0) check("full_rate_cycles", 128'(cycles), 128'd11);
    end
  endtask

  task automatic check_fips_table();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fips_round%0d", fips_tbl[i].rnd), got_key[fips_tbl[i].rnd], fips_tbl[i].key);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [127:0] ck;
    n_rst     = 1'b0;
    start     = 1'b0;
    key_ready = 1'b0;
    final_key = '0;
    build_sbox();
    fips_tbl[0] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    fips_tbl[1] = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips_tbl[2] = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips_tbl[3] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

    repeat (2) @(negedge clk);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_round_key", round_key, 128'h0);
    check("rst_round_num", round_num, 4'd0);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_key_valid", key_valid, 1'b0);

    // FIPS-197 sequence at full rate
    run_seq(FIPS_KEY, 0, -1);
    check_fips_table();
    idle_cycle();

    // back-pressure
    run_seq(FIPS_KEY, 1, -1);
    check_fips_table();
    idle_cycle();

    // start while busy at round 7
    run_seq(FIPS_KEY, 0, 7);
    check_fips_table();
    idle_cycle();

    // reset in the middle of a sequence
    expand(FIPS_KEY);
    start     = 1'b1;
    final_key = rk[10];
    @(negedge clk);
    start     = 1'b0;
    key_ready = 1'b1;
    cnt = 0;
    while (round_num != 4'd5 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("reached_round5", round_num, 4'd5);
    n_rst     = 1'b0;
    key_ready = 1'b0;
    @(negedge clk);
    check("midrst_key_valid", key_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_round_key", round_key, 128'h0);
    check("midrst_round_num", round_num, 4'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("postrst_idle", key_valid, 1'b0);
    run_seq(FIPS_KEY, 0, -1);
    check_fips_table();
    idle_cycle();

    // start in the cycle done is high: back-to-back sequences
    run_seq(128'h000102030405060708090a0b0c0d0e0f, 2, -1);
    run_seq(FIPS_KEY, 0, -1);
    check_fips_table();
    idle_cycle();

    // random keys
    for (int n = 0; n < 200; n++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      run_seq(ck, (n % 3 == 0) ? 0 : 2, (n % 7 == 0) ? int'($urandom_range(0, 10)) : -1);
      idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
